b_bit_serial_subtractor: RTL and testbench
==========================================

B_BIT_SERIAL_SUBTRACTOR -- requirements
Module: b_bit_serial_subtractor

Interface
REQ-001 SHALL have parameter B, default 32: operand/result width in bits.
REQ-002 SHALL have parameter W, default 8: slice width processed per cycle; B%W==0 and W<=B are required, else elaboration error.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: operands present.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port a, input, B: minuend.
REQ-008 SHALL have port b, input, B: subtrahend.
REQ-009 SHALL have port bin, input, 1: borrow-in.
REQ-010 SHALL have port out_valid, output, 1: result valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port d, output, B: difference, a-b-bin mod 2^B.
REQ-013 SHALL have port bout, output, 1: borrow-out (1 when a < b+bin, unsigned).
REQ-014 SHALL have port zero, output, 1: 1 when d==0.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready, latch a, b, bin, clear slice counter, clear d, go to RUN.
REQ-017 RUN: each cycle compute slice k (bits k*W+W-1..k*W) as a_slice-b_slice-borrow, write it into d, update borrow, increment k; borrow for k=0 is latched bin.
REQ-018 After slice B/W-1 is written, SHALL go to DONE with bout=final borrow and zero=(d==0); total latency from accept edge to out_valid high is exactly B/W cycles (4 for defaults).
REQ-019 DONE: out_valid=1; d, bout, zero held stable until out_valid&&out_ready, then go to IDLE in the same edge.
REQ-020 in_ready SHALL be 0 in RUN and DONE; inputs changing there SHALL have no effect.
REQ-021 out_valid SHALL be 0 outside DONE; d/bout/zero are only meaningful while out_valid=1.
REQ-022 No new operand is accepted in the edge that retires a result; the next accept occurs at the earliest one cycle later, from IDLE.
REQ-023 W==B SHALL be legal: single RUN cycle, latency 1.

Reset
REQ-024 While rst_n=0 at a clk edge: state=IDLE, slice counter=0, d=0, bout=0, zero=0, out_valid=0; in_ready=0 while rst_n=0.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered; the first accept after release starts a clean operation.

Configuration
REQ-026 Macro SUB_OVF_EN SHALL, when defined, add output ovf (1 bit): signed two's-complement overflow of a-b-bin, valid with out_valid, reset value 0.
REQ-027 Without SUB_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Shared package sub_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and default constants for B and W.
REQ-029 One sub-module sub_slice SHALL be used: combinational W-bit subtract with borrow-in/borrow-out, instantiated once and reused across cycles.

Verification (B=32, W=8)
REQ-030 a=5, b=3, bin=0 -> out_valid 4 cycles after accept, d=0x00000002, bout=0, zero=0.
REQ-031 a=0, b=1, bin=0 -> d=0xFFFFFFFF, bout=1, zero=0; with SUB_OVF_EN, ovf=0.
REQ-032 a=b=0x00001234, bin=0 -> d=0, zero=1, bout=0; a=0x00001234, b=0x00001233, bin=1 -> d=0, zero=1, bout=0.
REQ-033 out_ready held low for 3 cycles in DONE -> d, bout, zero, out_valid stable; in_ready=0; retire on the 4th cycle, then IDLE.
REQ-034 rst_n low for 1 cycle during RUN slice 2 -> out_valid never rises for that operand; the next op a=10, b=4 yields d=6 with 4-cycle latency.
REQ-035 SUB_OVF_EN: a=0x80000000, b=1, bin=0 -> d=0x7FFFFFFF, ovf=1, bout=0.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// FSM state encoding plus default operand and slice widths.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int B_DEF = 32;
   localparam int W_DEF = 8;

endpackage

// File: rtl/sub_slice.sv
// W-bit subtract with borrow-in and borrow-out.
// Purely combinational; the top reuses one copy every cycle.
module sub_slice
   import sub_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_bin,
   output logic [W-1:0] o_d,
   output logic         o_bout
);

   logic [W:0] w_full;

   // One extra bit catches the borrow out of the slice
   assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_bin};
   assign o_d    = w_full[W-1:0];
   assign o_bout = w_full[W];

endmodule

// File: rtl/b_bit_serial_subtractor.sv
// Bit-serial B-bit subtractor, W bits per cycle, valid/ready both sides.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module b_bit_serial_subtractor
   import sub_pkg::*;
#(
   parameter int B = B_DEF,
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [B-1:0] a,
   input  logic [B-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [B-1:0] d,
   output logic         bout,
`ifdef SUB_OVF_EN
   output logic         ovf,
`endif
   output logic         zero
);

   localparam int NS = B / W;
   localparam int KW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

   if ((W > B) || (W < 1) || ((B % W) != 0)) begin : g_bad_cfg
      $error("b_bit_serial_subtractor: need W<=B and B%%W==0");
   end

   state_t        r_state;
   logic [KW-1:0] r_k;
   logic [B-1:0]  r_a;
   logic [B-1:0]  r_b;
   logic          r_borrow;
   logic [B-1:0]  r_d;
   logic          r_bout;
   logic          r_zero;
   logic          r_out_valid;
`ifdef SUB_OVF_EN
   logic          r_ovf;
`endif

   logic [W-1:0]  w_a_sl;
   logic [W-1:0]  w_b_sl;
   logic [W-1:0]  w_diff;
   logic          w_bo;
   logic [B-1:0]  w_d_next;

   // Select the current slice and merge its difference into d
   always_comb begin
      w_a_sl   = r_a[int'(r_k)*W +: W];
      w_b_sl   = r_b[int'(r_k)*W +: W];
      w_d_next = r_d;
      w_d_next[int'(r_k)*W +: W] = w_diff;
   end

   sub_slice #(
      .W (W)
   ) u_slice (
      .i_a    (w_a_sl),
      .i_b    (w_b_sl),
      .i_bin  (r_borrow),
      .o_d    (w_diff),
      .o_bout (w_bo)
   );

   // Control FSM and datapath registers: accept, iterate slices, hold result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_borrow    <= 1'b0;
         r_d         <= '0;
         r_bout      <= 1'b0;
         r_zero      <= 1'b0;
         r_out_valid <= 1'b0;
`ifdef SUB_OVF_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_borrow <= bin;
                  r_k      <= '0;
                  r_d      <= '0;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_d      <= w_d_next;
               r_borrow <= w_bo;
               if (r_k == K_LAST) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_bout      <= w_bo;
                  r_zero      <= (w_d_next == '0);
`ifdef SUB_OVF_EN
                  // sign bit of the (B+1)-bit result vs. sign bit of d
                  r_ovf <= r_a[B-1] ^ r_b[B-1] ^ w_bo ^ w_d_next[B-1];
`endif
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = rst_n && (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign d         = r_d;
   assign bout      = r_bout;
   assign zero      = r_zero;
`ifdef SUB_OVF_EN
   assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_b_bit_serial_subtractor.sv
// Scoreboard bench for b_bit_serial_subtractor (B=32, W=8).
// Driver pushes model results; a negedge monitor pops and compares.
module tb_b_bit_serial_subtractor;

   localparam int B   = 32;
   localparam int W   = 8;
   localparam int LAT = B / W;

   typedef struct {
      logic [31:0] d;
      logic        bout;
      logic        zero;
      logic        ovf;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        bin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] d;
   logic        bout;
   logic        zero;
`ifdef SUB_OVF_EN
   logic        ovf;
`endif

   int   errs = 0;
   int   chks = 0;
   int   cyc = 0;
   int   rdy_mode = 0;
   exp_t sb[$];

   b_bit_serial_subtractor #(.B(B), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
`ifdef SUB_OVF_EN
      .ovf       (ovf),
`endif
      .zero      (zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(logic [31:0] x, logic [31:0] y,
                                  logic bi, int acc);
      exp_t   e;
      longint ux, uy, t, sx, sy, s;
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      t  = ux - uy - longint'(bi);
      sx = longint'($signed({{32{x[31]}}, x}));
      sy = longint'($signed({{32{y[31]}}, y}));
      s  = sx - sy - longint'(bi);
      e.d    = t[31:0];
      e.bout = (t < 0);
      e.zero = (t[31:0] == 32'd0);
      e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      e.acc  = acc;
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      chks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, req, cyc);
      end
   endtask

   // out_ready driver: 0=always high, 1=random, 2=held low
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // caller is at posedge+1; returns at posedge+1 after the accept edge
   task automatic issue(logic [31:0] x, logic [31:0] y, logic bi);
      bit ok = 0;
      a = x;
      b = y;
      bin = bi;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chks++;
         errs++;
         $display("FAIL accept_timeout: in_ready never high");
      end else begin
         sb.push_back(model(x, y, bi, cyc + 1));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      bin = 1'($urandom_range(0, 1));
   endtask

   // monitor state
   logic        prev_ov = 1'b0;
   logic [31:0] cap_d;
   logic        cap_bout;
   logic        cap_zero;

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            cap_d    = d;
            cap_bout = bout;
            cap_zero = zero;
            if (sb.size() == 0) begin
               chks++;
               errs++;
               $display("FAIL unexpected_out: out_valid with no op");
            end else begin
               chk("latency", 32'(cyc - sb[0].acc), 32'(LAT));
            end
         end else if (out_valid && prev_ov) begin
            chk("hold_d", d, cap_d);
            chk("hold_bout", 32'(bout), 32'(cap_bout));
            chk("hold_zero", 32'(zero), 32'(cap_zero));
         end
         if (out_valid)
            chk("in_ready_busy", 32'(in_ready), 32'd0);
         if (out_valid && out_ready && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("d", d, e.d);
            chk("bout", 32'(bout), 32'(e.bout));
            chk("zero", 32'(zero), 32'(e.zero));
`ifdef SUB_OVF_EN
            chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
         end
         prev_ov = out_valid;
      end
   end

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chks++;
         errs++;
         $display("FAIL drain_timeout: %0d ops pending", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      bit ok;
      rdy_mode = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_d", d, 32'd0);
      chk("rst_bout", 32'(bout), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
`ifdef SUB_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // directed cases
      issue(32'd5, 32'd3, 1'b0);
      issue(32'd0, 32'd1, 1'b0);
      issue(32'h1234, 32'h1234, 1'b0);
      issue(32'h1234, 32'h1233, 1'b1);
      issue(32'h8000_0000, 32'd1, 1'b0);
      issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      issue(32'h8000_0000, 32'd0, 1'b1);
      issue(32'd0, 32'hFFFF_FFFF, 1'b1);
      wait_idle();

      // hold result with out_ready low for 3 DONE cycles
      rdy_mode = 2;
      issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1;
            break;
         end
      end
      chk("stall_seen", 32'(ok), 32'd1);
      repeat (2) @(negedge clk);
      rdy_mode = 0;
      n = 3;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!out_valid) break;
         n++;
      end
      chk("stall_cycles", 32'(n), 32'd4);
      chk("stall_idle", 32'(in_ready), 32'd1);
      wait_idle();

      // abort with reset during RUN slice 2
      issue(32'd99, 32'd7, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_out", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      issue(32'd10, 32'd4, 1'b0);
      wait_idle();

      // randomized traffic with random backpressure
      rdy_mode = 1;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] x, y;
         x = $urandom;
         y = ($urandom_range(0, 7) == 0) ? x : $urandom;
         issue(x, y, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
